// File: rtl/alu16_result_stage.sv
// 16-bit ALU execute/result stage feeding a 2-entry result buffer; OR path via or16.
// Latency: a result accepted at edge N is at the buffer head right after edge N when the buffer was empty.
// Backpressure: in_ready is registered (buffer not full next cycle), so out_ready has no combinational path to in_ready.

module or16 (
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic [15:0] y
);
    assign y = a | b;
endmodule

module alu16_result_stage #(
    parameter bit ACC_EN = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] in1,
    input  logic [15:0] in2,
    input  logic [2:0]  op,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out,
    output logic        z,
    output logic        c,
    output logic        n,
    output logic        v
);
    localparam logic [2:0] OP_AND  = 3'b000;
    localparam logic [2:0] OP_OR   = 3'b001;
    localparam logic [2:0] OP_XOR  = 3'b010;
    localparam logic [2:0] OP_NOT  = 3'b011;
    localparam logic [2:0] OP_ADD  = 3'b100;
    localparam logic [2:0] OP_SUB  = 3'b101;
    localparam logic [2:0] OP_PASS = 3'b110;
    localparam logic [2:0] OP_ACC  = 3'b111;

    typedef struct packed {
        logic [15:0] res;
        logic        z;
        logic        c;
        logic        n;
        logic        v;
    } entry_t;

    logic [15:0] acc;
    logic [15:0] or_y;
    logic [15:0] a_op;
    logic [15:0] b_op;
    logic        cin;
    logic        arith;
    logic [16:0] sum;
    entry_t      new_e;

    entry_t head, head_n;
    entry_t tail, tail_n;
    logic   out_valid_n;
    logic   tail_vld, tail_vld_n;
    logic   push, pop;

    or16 u_or16 (
        .a (in1),
        .b (in2),
        .y (or_y)
    );

    always_comb begin
        a_op  = in1;
        b_op  = in2;
        cin   = 1'b0;
        arith = 1'b0;
        case (op)
            OP_ADD: arith = 1'b1;
            OP_SUB: begin
                b_op  = ~in2;
                cin   = 1'b1;
                arith = 1'b1;
            end
            OP_ACC: begin
                if (ACC_EN) begin
                    a_op  = acc;
                    b_op  = in1;
                    arith = 1'b1;
                end
            end
            default: ;
        endcase

        sum = {1'b0, a_op} + {1'b0, b_op} + {16'b0, cin};

        new_e = '0;
        case (op)
            OP_AND:  new_e.res = in1 & in2;
            OP_OR:   new_e.res = or_y;
            OP_XOR:  new_e.res = in1 ^ in2;
            OP_NOT:  new_e.res = ~in1;
            OP_PASS: new_e.res = in1;
            default: new_e.res = arith ? sum[15:0] : in1;
        endcase
        new_e.z = (new_e.res == 16'h0000);
        new_e.n = new_e.res[15];
        new_e.c = arith & sum[16];
        // Overflow: both effective operands share a sign that the result does not.
        new_e.v = arith & (a_op[15] == b_op[15]) & (new_e.res[15] != a_op[15]);
    end

    assign push = in_valid & in_ready;
    assign pop  = out_valid & out_ready;

    // Head doubles as the output register so it holds its value once drained.
    always_comb begin
        head_n      = head;
        tail_n      = tail;
        out_valid_n = out_valid;
        tail_vld_n  = tail_vld;
        if (pop) begin
            if (tail_vld) begin
                head_n     = tail;
                tail_n     = new_e;
                tail_vld_n = push;
            end else if (push) begin
                head_n = new_e;
            end else begin
                out_valid_n = 1'b0;
            end
        end else if (push) begin
            if (!out_valid) begin
                head_n      = new_e;
                out_valid_n = 1'b1;
            end else begin
                tail_n     = new_e;
                tail_vld_n = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head      <= '0;
            tail      <= '0;
            out_valid <= 1'b0;
            tail_vld  <= 1'b0;
            acc       <= 16'h0000;
            in_ready  <= 1'b0;
        end else begin
            head      <= head_n;
            tail      <= tail_n;
            out_valid <= out_valid_n;
            tail_vld  <= tail_vld_n;
            in_ready  <= !(out_valid_n && tail_vld_n);
            if (ACC_EN && push) begin
                acc <= new_e.res;
            end
        end
    end

    assign out = head.res;
    assign z   = head.z;
    assign c   = head.c;
    assign n   = head.n;
    assign v   = head.v;
endmodule

// File: tb/tb_alu16_result_stage.sv
// Directed bench for alu16_result_stage: one instance with the accumulator, one without.
module tb_alu16_result_stage;
    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [15:0] in1, in2;
    logic [2:0]  op;
    logic        out_ready;

    logic        in_ready1, out_valid1, z1, c1, n1, v1;
    logic [15:0] out1;
    logic        in_ready0, out_valid0, z0, c0, n0, v0;
    logic [15:0] out0;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    alu16_result_stage #(.ACC_EN(1'b1)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1),
        .in1(in1), .in2(in2), .op(op), .out_valid(out_valid1), .out_ready(out_ready),
        .out(out1), .z(z1), .c(c1), .n(n1), .v(v1)
    );

    alu16_result_stage #(.ACC_EN(1'b0)) dut_noacc (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready0),
        .in1(in1), .in2(in2), .op(op), .out_valid(out_valid0), .out_ready(out_ready),
        .out(out0), .z(z0), .c(c0), .n(n0), .v(v0)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Head state of the accumulating instance: {out_valid, out, z, c, n, v}
    task automatic chk_head(input string tag, input logic vld, input logic [15:0] res,
                            input logic ez, input logic ec, input logic en, input logic ev);
        chk(tag, {11'b0, out_valid1, out1, z1, c1, n1, v1}, {11'b0, vld, res, ez, ec, en, ev});
    endtask

    task automatic drive(input logic vld, input logic [2:0] o, input logic [15:0] a, input logic [15:0] b);
        in_valid = vld;
        op       = o;
        in1      = a;
        in2      = b;
    endtask

    initial begin
        rst = 1'b1; out_ready = 1'b0;
        drive(1'b1, 3'b100, 16'h1111, 16'h2222);
        tick(); tick();
        chk_head("reset_state", 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("reset_in_ready", {31'b0, in_ready1}, 32'd0);

        rst = 1'b0; drive(1'b0, 3'b000, 16'h0, 16'h0);
        tick();
        chk("in_ready_after_reset", {31'b0, in_ready1}, 32'd1);
        chk("empty_after_reset", {31'b0, out_valid1}, 32'd0);

        // OR through or16, delivered once
        out_ready = 1'b1;
        drive(1'b1, 3'b001, 16'h00F0, 16'h0F0F);
        tick();
        chk_head("or", 1'b1, 16'h0FFF, 1'b0, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 3'b001, 16'h00F0, 16'h0F0F);
        tick();
        chk_head("or_drained_hold", 1'b0, 16'h0FFF, 1'b0, 1'b0, 1'b0, 1'b0);

        // Back-to-back arithmetic at one per cycle (push+pop at count 1)
        drive(1'b1, 3'b100, 16'hFFFF, 16'h0001);
        tick();
        chk_head("add_wrap", 1'b1, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b0);
        drive(1'b1, 3'b100, 16'h7FFF, 16'h0001);
        tick();
        chk_head("add_ovf", 1'b1, 16'h8000, 1'b0, 1'b0, 1'b1, 1'b1);
        drive(1'b1, 3'b101, 16'h0003, 16'h0005);
        tick();
        chk_head("sub_borrow", 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b1, 1'b0);
        drive(1'b1, 3'b101, 16'h8000, 16'h0001);
        tick();
        chk_head("sub_ovf", 1'b1, 16'h7FFF, 1'b0, 1'b1, 1'b0, 1'b1);
        drive(1'b1, 3'b000, 16'hF0F0, 16'h3C3C);
        tick();
        chk_head("and", 1'b1, 16'h3030, 1'b0, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 3'b010, 16'hFFFF, 16'hFFFF);
        tick();
        chk_head("xor_zero", 1'b1, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 3'b011, 16'h0F00, 16'h0000);
        tick();
        chk_head("not", 1'b1, 16'hF0FF, 1'b0, 1'b0, 1'b1, 1'b0);
        drive(1'b1, 3'b110, 16'h8001, 16'h1234);
        tick();
        chk_head("pass", 1'b1, 16'h8001, 1'b0, 1'b0, 1'b1, 1'b0);
        drive(1'b0, 3'b110, 16'h0000, 16'h0000);
        tick();
        chk("drained", {31'b0, out_valid1}, 32'd0);

        // Backpressure: three ADDs against a stalled consumer
        out_ready = 1'b0;
        drive(1'b1, 3'b100, 16'h0001, 16'h0001);
        tick();
        chk_head("bp_first", 1'b1, 16'h0002, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("bp_ready_cnt1", {31'b0, in_ready1}, 32'd1);
        drive(1'b1, 3'b100, 16'h0002, 16'h0002);
        tick();
        chk("bp_full_ready", {31'b0, in_ready1}, 32'd0);
        chk("bp_head_hold", {16'b0, out1}, 32'h0002);
        drive(1'b1, 3'b100, 16'h0003, 16'h0003);
        tick();
        chk("bp_third_refused", {31'b0, in_ready1}, 32'd0);
        chk_head("bp_head_still", 1'b1, 16'h0002, 1'b0, 1'b0, 1'b0, 1'b0);
        out_ready = 1'b1;
        tick();
        chk_head("bp_second_out", 1'b1, 16'h0004, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("bp_ready_again", {31'b0, in_ready1}, 32'd1);
        tick();
        chk_head("bp_third_out", 1'b1, 16'h0006, 1'b0, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 3'b100, 16'h0000, 16'h0000);
        tick();
        chk("bp_drained", {31'b0, out_valid1}, 32'd0);

        // Accumulator, with and without ACC_EN
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        drive(1'b1, 3'b111, 16'h0005, 16'h0000);
        tick();
        chk_head("acc_1", 1'b1, 16'h0005, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("noacc_1", {15'b0, out_valid0, out0}, {15'b0, 1'b1, 16'h0005});
        tick();
        chk_head("acc_2", 1'b1, 16'h000A, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("noacc_2", {15'b0, out_valid0, out0}, {15'b0, 1'b1, 16'h0005});
        tick();
        chk_head("acc_3", 1'b1, 16'h000F, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("noacc_3", {15'b0, out_valid0, out0}, {15'b0, 1'b1, 16'h0005});

        // Reset with a full buffer
        out_ready = 1'b0;
        drive(1'b1, 3'b100, 16'h8000, 16'h8000);
        tick();
        tick();
        chk("mid_full", {31'b0, in_ready1}, 32'd0);
        rst = 1'b1;
        drive(1'b0, 3'b100, 16'h0000, 16'h0000);
        tick();
        chk_head("mid_reset", 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("mid_reset_ready", {31'b0, in_ready1}, 32'd0);
        rst = 1'b0;
        tick();
        chk("mid_ready_back", {31'b0, in_ready1}, 32'd1);
        out_ready = 1'b1;
        drive(1'b1, 3'b111, 16'h0007, 16'h0000);
        tick();
        chk_head("acc_after_reset", 1'b1, 16'h0007, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("noacc_after_reset", {16'b0, out0}, 32'h0007);
        drive(1'b0, 3'b000, 16'h0000, 16'h0000);
        tick();
        chk("final_drain", {31'b0, out_valid1}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
